// File: rtl/serial_frame_tx.sv
// Master-side serializer: sync run, start low, header byte, then a payload
// streamed from a valid/ready source at 2 clocks per bit, LSB first.
module serial_frame_tx #(
  parameter int          SYNC_LEN = 6,
  parameter logic [7:0]  HEADER   = 8'h0A,
  parameter int          LEN_W    = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_frame,
  input  logic [LEN_W-1:0] frame_len,
  input  logic [7:0]       byte_data,
  input  logic             byte_valid,
  output logic             byte_ready,
  output logic             tx,
  output logic             busy,
  output logic             frame_done,
  output logic             underrun
);

  typedef enum logic [2:0] {IDLE, SYNC, START, HDR, PAY, DONE} state_e;

  localparam logic [3:0] SyncLast = 4'(SYNC_LEN - 1);

  state_e           state_q;
  logic [3:0]       cnt_q;
  logic [LEN_W-1:0] remain_q;
  logic [7:0]       shift_q;
  logic             tx_q;
  logic             busy_q;
  logic             done_q;

  logic             byteSlot;
  logic             moreBytes;
  logic [3:0]       cntNext_d;

  // The last cycle of a byte (bit 7, phase 1) is the only hand-off point.
  always_comb begin
    byteSlot   = ((state_q == HDR) || (state_q == PAY)) && (cnt_q == 4'hF);
    moreBytes  = (remain_q != '0);
    byte_ready = !reset && byteSlot && moreBytes;
    underrun   = byte_ready && !byte_valid;
    cntNext_d  = cnt_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      remain_q <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (start_frame) begin
            state_q  <= SYNC;
            remain_q <= frame_len;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
          end
        end
        SYNC: begin
          if (cnt_q == SyncLast) begin
            state_q <= START;
            cnt_q   <= '0;
            tx_q    <= 1'b0;
          end else begin
            cnt_q <= cntNext_d;
          end
        end
        START: begin
          state_q <= HDR;
          shift_q <= HEADER;
          cnt_q   <= '0;
          tx_q    <= HEADER[0];
        end
        HDR, PAY: begin
          // tx is registered, so it is driven from the bit the next cycle owns.
          if (!byteSlot) begin
            cnt_q <= cntNext_d;
            tx_q  <= shift_q[cntNext_d[3:1]];
          end else if (moreBytes) begin
            cnt_q <= '0;
            if (byte_valid) begin
              state_q  <= PAY;
              shift_q  <= byte_data;
              remain_q <= remain_q - LEN_W'(1);
              tx_q     <= byte_data[0];
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              tx_q    <= 1'b1;
            end
          end else begin
            state_q <= DONE;
            cnt_q   <= '0;
            done_q  <= 1'b1;
            tx_q    <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          tx_q    <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: doc/serial_frame_tx.md
Name: serial_frame_tx

Overview:
Master-side serializer that drives the single-wire serial link into the slave receive state machine.
- Each frame is: a sync run (line high), a one-cycle start low, header byte 0x0A, then frame_len payload bytes taken from an upstream valid/ready source.
- Bit coding matches the receiver: 2 clocks per bit, low nibble first, LSB first within each nibble, bytes back-to-back with no gaps.

Parameters:
SYNC_LEN, 6, cycles tx is held high before the start low; legal range 4..15
HEADER, 8'h0A, first byte of every frame
LEN_W, 5, width of frame_len; maximum payload is 2^LEN_W-1 bytes

Ports:
clk  input  1  system clock, single clock domain
reset  input  1  synchronous, active-high reset
start_frame  input  1  one-cycle request to send a frame; sampled only in IDLE
frame_len  input  LEN_W  payload byte count; captured when start_frame is accepted
byte_data  input  8  payload byte from upstream
byte_valid  input  1  byte_data is valid
byte_ready  output  1  payload byte accepted this cycle when byte_valid is also high
tx  output  1  serial line; idles high
busy  output  1  high from the cycle after acceptance until frame end
frame_done  output  1  one-cycle pulse: frame completed normally
underrun  output  1  one-cycle pulse: frame aborted, payload byte unavailable

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Reset values: tx=1, busy=0, byte_ready=0, frame_done=0, underrun=0, state=IDLE, all counters and the shift register cleared. A reset mid-frame forces tx=1 at the next edge; the partial frame is dropped and no pulse is issued.
- States: IDLE, SYNC, START, HDR, PAY, DONE.
- IDLE: tx=1. If start_frame=1, capture frame_len and go to SYNC; busy=1 from the next cycle. start_frame in any other state is ignored.
- SYNC: tx=1 for exactly SYNC_LEN cycles, then START.
- START: tx=0 for exactly 1 cycle, then HDR. The receiver samples bit 0 on the following cycle.
- HDR / PAY bit timing: a 4-bit counter (bit index 0..7, phase 0..1) gives 16 cycles per byte. tx = shift[bit_index], held for both phases.
- Shift register: loaded with HEADER on entry to HDR, then with each accepted payload byte.
- byte_ready: asserted combinationally only on the last cycle (bit 7, phase 1) of HDR or of a PAY byte, and only if payload bytes remain.
  - byte_valid=1 on that cycle: transfer; the next cycle begins the new byte in PAY with no gap.
  - byte_valid=0 on that cycle: underrun pulse, tx=1 next cycle, go to IDLE, busy=0 next cycle. No frame_done.
- Remaining-byte counter: decrements on each transfer.
  - frame_len=0: header only; byte_ready never asserts, and HDR goes to DONE after 16 cycles.
  - After the last payload byte's 16 cycles, go to DONE.
- DONE: 1 cycle with tx=1 and frame_done=1, then IDLE with busy=0. A start_frame can be accepted the cycle after DONE.
- byte_data/byte_valid are ignored outside the byte_ready cycle. byte_data is latched only on a transfer.
- Counters never wrap within a frame. frame_len = 2^LEN_W-1 must complete correctly.
- Frame length in cycles: SYNC_LEN + 1 + 16*(1+frame_len) + 1 (DONE).

Test Plan:
- Reset check: assert reset for 3 cycles with random inputs -> tx=1, busy=0, byte_ready=0, frame_done=0, underrun=0 throughout and on the cycle after release.
- Header-only frame: start_frame with frame_len=0 -> tx high for 6 cycles, low 1 cycle, then 0x0A bits 0,1,0,1,0,0,0,0 each for 2 cycles, then frame_done pulse 23 cycles after busy rises. byte_ready is never high.
- Two-byte frame: frame_len=2, byte_valid held high, bytes 0xA5 then 0xFF -> byte_ready high exactly on the last header cycle and the last 0xA5 cycle. 0xA5 serializes as 1,0,1,0,0,1,0,1 (×2 cycles each); 0xFF as 16 high cycles. frame_done follows 1 cycle after the last bit.
- Underrun: frame_len=3, byte_valid low when the second payload byte is due -> underrun pulse that cycle, tx=1 and busy=0 next cycle, no frame_done.
- Reset mid-frame: assert reset during bit 3 of the header -> tx=1 and busy=0 on the next edge. A new start_frame after release produces a full, correct frame.
- Back-to-back and ignored requests: start_frame held high continuously with frame_len=1 -> consecutive frames separated by exactly one IDLE cycle after DONE; requests during busy are not queued.
